// File: rtl/lzc_seq.sv
// Sequential leading-zero counter/normaliser: scans one nibble per cycle from the MSB.
// Optional feature macro LZC_NORM_EN builds the shifting work register and drives out_norm.
module lzc_seq #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm
);

  localparam int NN = WIDTH / 4;
  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NN - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(WIDTH);
  localparam logic [CW-1:0] NIB_COUNT  = CW'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [1:0] lzd4(input logic [3:0] nib);
    logic [1:0] lz;
    casez (nib)
      4'b1???: lz = 2'd0;
      4'b01??: lz = 2'd1;
      4'b001?: lz = 2'd2;
      default: lz = 2'd3;
    endcase
    return lz;
  endfunction

  state_t            state_r, state_s;
  logic [CW-1:0]     count_r, count_s;
  logic [IW-1:0]     idx_r, idx_s;
  logic              zero_r, zero_s;
  logic [3:0]        nib_s;
  logic [1:0]        lz_s;
  logic              in_ready_s;
  logic              accept_s;
  logic [WIDTH-1:0]  work_r, work_s;

`ifdef LZC_NORM_EN
  // The current nibble always sits at the top of the shifting work register.
  always_comb begin
    nib_s = work_r[WIDTH-1 -: 4];
  end
  assign out_norm = work_r;
`else
  // Operand stays put; the nibble under inspection is picked by index.
  always_comb begin
    nib_s = 4'h0;
    for (int i = 0; i < NN; i++) begin
      nib_s = (idx_r == IW'(i)) ? work_r[WIDTH-1-4*i -: 4] : nib_s;
    end
  end
  assign out_norm = '0;
`endif

  assign lz_s = lzd4(nib_s);

  // Ready is the only combinational output; held low throughout reset.
  always_comb begin
    in_ready_s = 1'b0;
    if (!rst_n) begin
      in_ready_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    in_ready_s = 1'b1;
        DONE:    in_ready_s = out_ready;
        default: in_ready_s = 1'b0;
      endcase
    end
  end

  assign accept_s = in_valid & in_ready_s;

  // Next-state and datapath update for the scan FSM.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    idx_s   = idx_r;
    zero_s  = zero_r;
    work_s  = work_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          work_s  = in_data;
          count_s = '0;
          idx_s   = '0;
          zero_s  = 1'b0;
          state_s = SCAN;
        end else if (state_r == DONE && out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end
      SCAN: begin
        if (nib_s != 4'h0) begin
          count_s = count_r + {{(CW-2){1'b0}}, lz_s};
`ifdef LZC_NORM_EN
          work_s  = work_r << lz_s;
`endif
          state_s = DONE;
        end else if (idx_r != LAST_IDX) begin
          count_s = count_r + NIB_COUNT;
`ifdef LZC_NORM_EN
          work_s  = work_r << 4;
`endif
          idx_s   = idx_r + {{(IW-1){1'b0}}, 1'b1};
          state_s = SCAN;
        end else begin
          count_s = FULL_COUNT;
          zero_s  = 1'b1;
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      count_r <= '0;
      idx_r   <= '0;
      zero_r  <= 1'b0;
      work_r  <= '0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      idx_r   <= idx_s;
      zero_r  <= zero_s;
      work_r  <= work_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (state_r == DONE);
  assign out_count = count_r;
  assign out_zero  = zero_r;

endmodule

// File: tb/tb_lzc_seq.sv
// Self-checking bench for lzc_seq at WIDTH=16 and WIDTH=32 against a bit-scan reference model.
module tb_lzc_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel32;
  logic        tb_valid;
  logic        tb_ready;
  logic [31:0] tb_data;

  logic        ir16, ov16, z16;
  logic [4:0]  c16;
  logic [15:0] n16;
  logic        ir32, ov32, z32;
  logic [5:0]  c32;
  logic [31:0] n32;

  logic        ir_m, ov_m, z_m;
  logic [5:0]  cnt_m;
  logic [31:0] nrm_m;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lzc_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(tb_valid & ~sel32), .in_ready(ir16), .in_data(tb_data[15:0]),
    .out_valid(ov16), .out_ready(tb_ready & ~sel32),
    .out_count(c16), .out_zero(z16), .out_norm(n16)
  );

  lzc_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(tb_valid & sel32), .in_ready(ir32), .in_data(tb_data),
    .out_valid(ov32), .out_ready(tb_ready & sel32),
    .out_count(c32), .out_zero(z32), .out_norm(n32)
  );

  assign ir_m  = sel32 ? ir32 : ir16;
  assign ov_m  = sel32 ? ov32 : ov16;
  assign z_m   = sel32 ? z32  : z16;
  assign cnt_m = sel32 ? c32  : {1'b0, c16};
  assign nrm_m = sel32 ? n32  : {16'h0000, n16};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int ref_lz(input logic [31:0] d, input int w);
    for (int i = w - 1; i >= 0; i--) begin
      if (d[i]) return w - 1 - i;
    end
    return w;
  endfunction

  function automatic logic [31:0] ref_norm(input logic [31:0] d, input int w);
    logic [31:0] r;
    r = d << ref_lz(d, w);
    if (w == 16) r = r & 32'h0000FFFF;
`ifndef LZC_NORM_EN
    r = 32'h0;
`endif
    return r;
  endfunction

  // Wait for the result, check it, optionally backpressure and retire it.
  task automatic finish_op(input logic [31:0] d, input int lat0, input int hold, input bit retire);
    int w, c, lat;
    logic [31:0] en;
    w   = sel32 ? 32 : 16;
    c   = ref_lz(d, w);
    en  = ref_norm(d, w);
    lat = lat0;
    while (!ov_m && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, (c == w) ? (w / 4 + 1) : (c / 4 + 2));
    check("count", {26'h0, cnt_m}, c);
    check("zero", {31'h0, z_m}, {31'h0, c == w});
    check("norm", nrm_m, en);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", {31'h0, ov_m}, 32'h1);
      check("hold_in_ready", {31'h0, ir_m}, 32'h0);
      check("hold_count", {26'h0, cnt_m}, c);
      check("hold_norm", nrm_m, en);
    end
    if (retire) begin
      tb_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tb_ready = 1'b0;
      check("retired", {31'h0, ov_m}, 32'h0);
    end
  endtask

  task automatic run_op(input logic [31:0] d, input int hold, input bit retire);
    @(negedge clk);
    check("in_ready_idle", {31'h0, ir_m}, 32'h1);
    tb_valid = 1'b1;
    tb_data  = d;
    tb_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tb_valid = 1'b0;
    finish_op(d, 1, hold, retire);
  endtask

  initial begin
    bit saw_valid;
    logic [31:0] d;
    rst_n    = 1'b0;
    sel32    = 1'b0;
    tb_valid = 1'b0;
    tb_ready = 1'b0;
    tb_data  = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'h0, ov16}, 32'h0);
    check("rst_in_ready", {31'h0, ir16}, 32'h0);
    check("rst_count", {27'h0, c16}, 32'h0);
    check("rst_zero", {31'h0, z16}, 32'h0);
    check("rst_norm", {16'h0, n16}, 32'h0);
    check("rst_valid32", {31'h0, ov32}, 32'h0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", {31'h0, ir16}, 32'h1);

    run_op(32'h8000, 0, 1'b1);
    run_op(32'h0300, 0, 1'b1);
    run_op(32'h0000, 0, 1'b1);
    run_op(32'h0001, 5, 1'b0);

    // Retire and accept on the same edge.
    @(negedge clk);
    tb_ready = 1'b1;
    tb_valid = 1'b1;
    tb_data  = 32'h00F0;
    #1;
    check("b2b_in_ready", {31'h0, ir_m}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    tb_valid = 1'b0;
    tb_ready = 1'b0;
    check("b2b_retired", {31'h0, ov_m}, 32'h0);
    finish_op(32'h00F0, 1, 0, 1'b1);

    // Abort a scan with reset.
    @(negedge clk);
    tb_valid = 1'b1;
    tb_data  = 32'h0001;
    @(posedge clk);
    @(negedge clk);
    tb_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", {31'h0, ov16}, 32'h0);
    check("abort_in_ready", {31'h0, ir16}, 32'h0);
    check("abort_count", {27'h0, c16}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ov16) saw_valid = 1'b1;
    end
    check("abort_no_result", {31'h0, saw_valid}, 32'h0);
    run_op(32'h8000, 0, 1'b1);

    for (int r = 0; r < 30; r++) begin
      d = (32'($urandom) & 32'h0000FFFF) >> $urandom_range(0, 16);
      run_op(d, $urandom_range(0, 2), 1'b1);
    end

    sel32 = 1'b1;
    for (int k = 0; k < 32; k++) begin
      d = 32'h1 << k;
      run_op(d, 0, 1'b1);
    end
    run_op(32'h0, 0, 1'b1);
    for (int r = 0; r < 30; r++) begin
      d = 32'($urandom) >> $urandom_range(0, 32);
      run_op(d, $urandom_range(0, 2), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
